// File: rtl/feed_arbiter.sv
// Round-robin, message-granular arbiter feeding one parser stream from N_FEEDS feed FIFOs.
// A granted feed that stalls mid-message for TIMEOUT_CYC idle cycles is aborted.
module feed_arbiter #(
    parameter int N_FEEDS     = 4,
    parameter int DATA_WIDTH  = 64,
    parameter int TIMEOUT_CYC = 256,
    parameter int SRC_W       = $clog2(N_FEEDS)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_FEEDS-1:0]            req_valid,
    input  logic [N_FEEDS*DATA_WIDTH-1:0] req_data,
    input  logic [N_FEEDS*8-1:0]          req_type,
    input  logic [N_FEEDS-1:0]            req_last,
    output logic [N_FEEDS-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [7:0]                    out_type,
    output logic                          out_last,
    input  logic                          out_ready,
    output logic [SRC_W-1:0]              out_src,
    output logic                          out_abort,
    output logic [31:0]                   msg_count,
    output logic [31:0]                   timeout_count,
    output logic                          busy
);

    localparam int unsigned NF = N_FEEDS;
    localparam logic [15:0] STALL_MAX = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {IDLE, GRANT} state_t;

    state_t           state_q, state_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [SRC_W-1:0] last_grant_q, last_grant_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [15:0]      stall_q, stall_d;
    logic [31:0]      msg_count_q, msg_count_d;
    logic [31:0]      timeout_count_q, timeout_count_d;

    logic             found;
    logic [SRC_W-1:0] win;
    int unsigned      idx;
    int unsigned      g_idx;

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        out_src_d       = out_src_q;
        stall_d         = stall_q;
        msg_count_d     = msg_count_q;
        timeout_count_d = timeout_count_q;
        req_ready       = '0;
        out_valid       = 1'b0;
        out_data        = '0;
        out_type        = '0;
        out_last        = 1'b0;
        out_abort       = 1'b0;
        busy            = 1'b0;
        found           = 1'b0;
        win             = '0;
        idx             = 0;
        g_idx           = 32'(grant_q);

        // Search upward from the feed after the last grant, wrapping once around.
        for (int unsigned k = 1; k <= NF; k++) begin
            idx = (32'(last_grant_q) + k) % NF;
            if (!found && req_valid[idx[SRC_W-1:0]]) begin
                found = 1'b1;
                win   = idx[SRC_W-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = win;
                    out_src_d = win;
                    stall_d   = '0;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                busy               = 1'b1;
                out_valid          = req_valid[grant_q];
                out_data           = req_data[g_idx*DATA_WIDTH +: DATA_WIDTH];
                out_type           = req_type[g_idx*8 +: 8];
                out_last           = req_last[grant_q];
                req_ready[grant_q] = out_ready;
                if (out_valid && out_ready) begin
                    stall_d = '0;
                    if (out_last) begin
                        msg_count_d  = msg_count_q + 32'd1;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end
                end else if (!req_valid[grant_q]) begin
                    // Only an empty source counts toward the abort; parser backpressure holds.
                    if (stall_q == STALL_MAX) begin
                        out_abort       = 1'b1;
                        timeout_count_d = timeout_count_q + 32'd1;
                        last_grant_d    = grant_q;
                        state_d         = IDLE;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            grant_q         <= '0;
            last_grant_q    <= SRC_W'(N_FEEDS - 1);
            out_src_q       <= '0;
            stall_q         <= '0;
            msg_count_q     <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            out_src_q       <= out_src_d;
            stall_q         <= stall_d;
            msg_count_q     <= msg_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign out_src       = out_src_q;
    assign msg_count     = msg_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: doc/feed_arbiter.md
Name: feed_arbiter

Overview:
- Shares one market_data_processor input stream between N_FEEDS exchange feed channels.
- Grants are round-robin at message granularity. A message is a burst of beats ending with last. Once a feed is granted, its message goes through without interleaving.
- Aborts a granted message whose source stalls mid-message, so one dead feed cannot lock the parser.
- Sits between the feed receive FIFOs and the parser's data_valid/data_in/data_type/data_ready port.

Parameters:
- N_FEEDS, 4, number of requesting feeds (2..8).
- DATA_WIDTH, 64, beat width; matches the parser data_in.
- TIMEOUT_CYC, 256, idle-source cycles mid-message before abort (1..65535).
- SRC_W, $clog2(N_FEEDS), width of the source index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- req_valid  in  N_FEEDS  per-feed beat valid.
- req_data  in  N_FEEDS*DATA_WIDTH  per-feed beat; feed i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- req_type  in  N_FEEDS*8  per-feed ITCH message type; feed i occupies [i*8 +: 8].
- req_last  in  N_FEEDS  per-feed final-beat flag.
- req_ready  out  N_FEEDS  per-feed beat accept.
- out_valid  out  1  to parser data_valid.
- out_data  out  DATA_WIDTH  to parser data_in.
- out_type  out  8  to parser data_type.
- out_last  out  1  final beat of the current message.
- out_ready  in  1  from parser data_ready.
- out_src  out  SRC_W  index of the granted feed.
- out_abort  out  1  one-cycle pulse when the current message is abandoned.
- msg_count  out  32  messages forwarded completely.
- timeout_count  out  32  aborted messages.
- busy  out  1  a grant is held.

Interface rule (already decided): single clock clk; reset rst_n is asynchronous and active-low.

Behaviour:
- Reset values:
  - All outputs 0; req_ready all 0.
  - State IDLE.
  - last_grant = N_FEEDS-1, so the first grant searches from feed 0.
  - Stall counter 0.
- A beat transfers on a cycle where out_valid && out_ready.
- State IDLE:
  - busy=0, out_valid=0, req_ready=0.
  - If any req_valid bit is set, the winner is the first set bit searching upward from (last_grant+1) mod N_FEEDS, with wrap.
  - Register grant=winner and out_src=winner; go to GRANT next cycle.
  - This costs one bubble cycle per message.
- State GRANT (g = grant):
  - Combinational pass-through: out_valid=req_valid[g], out_data, out_type and out_last come from feed g, and req_ready[g]=out_ready.
  - All other req_ready bits are 0. busy=1.
- Message completion:
  - On a transfer with req_last[g]=1: msg_count+1, last_grant<=g, go to IDLE.
  - The next arbitration happens in the IDLE cycle, so back-to-back messages from different feeds are separated by exactly one idle cycle.
- Stall counter:
  - Cleared on every transfer and on entry to GRANT.
  - Increments each GRANT cycle with req_valid[g]=0.
  - Cycles with req_valid[g]=1 and out_ready=0 are parser backpressure; they hold the counter and do not count.
- Timeout abort:
  - When the stall counter reaches TIMEOUT_CYC-1 and req_valid[g] is still 0, pulse out_abort=1 for that cycle, set timeout_count+1 and last_grant<=g, and go to IDLE.
  - Remaining beats from feed g are then treated as a new message when feed g is next granted.
- The grant never changes mid-message. New req_valid on other feeds is ignored until IDLE.
- If the source drops req_valid for a few cycles without reaching the timeout, the message resumes normally.
- Counters wrap at 2^32.
- out_type is forwarded on every beat; the parser latches it on the first beat.
- Reset asserted mid-message: grant is dropped immediately, all outputs return to reset values, and no abort pulse or counter increment occurs.
- A single-beat message (req_last=1 on the first beat) is legal: GRANT lasts one cycle if out_ready=1.

Test Plan:
1. Feed 0 only, 3 beats 0x11/0x22/0x33, type 0x41, last on beat 3, out_ready=1 → IDLE 1 cycle, then 3 out beats with out_src=0; msg_count=1; req_ready[0] high only during GRANT.
2. Feeds 0, 1 and 2 each hold a 1-beat message from reset → out_src sequence 0,1,2 with one idle cycle between; then feed 0 presents again → granted 0 after 2 (wrap).
3. Feed 1 mid-message (beat 2 of 4) while feed 2 asserts valid → all 4 feed-1 beats complete with req_ready[2]=0 throughout, then feed 2 is granted.
4. Feed 3 granted, req_valid=1, out_ready held 0 for 1000 cycles → no abort, timeout_count=0; out_ready=1 → beat transfers.
5. TIMEOUT_CYC=16, feed 0 sends beat 1 then drops valid → out_abort pulses exactly 16 cycles after the transfer, timeout_count=1, msg_count unchanged, arbiter returns to IDLE and grants feed 1 if it is pending.
6. rst_n pulsed low mid-message on feed 2 → out_valid, busy and req_ready go to 0 asynchronously; after release, counters=0 and the first grant goes to the lowest pending feed.
